sprf_addr_gen: RTL and testbench

SPRF_ADDR_GEN -- requirements
Module: sprf_addr_gen

---
 rtl/sprf_addr_gen.sv | 103 ++++++++++
 tb/tb_sprf_addr_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sprf_addr_gen.sv
// Special-purpose pointer register file: per-pointer cur/base/limit registers that
// generate registered indirect data-memory addresses with circular post-modify.
module sprf_addr_gen #(
  parameter int DMEMADDRW = 10,
  parameter int NPTR      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t_cs,
  input  logic                 ipt_dec_to_sprf_wr_en,
  input  logic [1:0]           ipt_dec_to_sprf_wr_sel,
  input  logic [1:0]           ipt_dec_to_sprf_wr_fld,
  input  logic [DMEMADDRW-1:0] ipt_dec_to_sprf_wr_data,
  input  logic                 ipt_dec_to_sprf_rd_en,
  input  logic [1:0]           ipt_dec_to_sprf_rd_sel,
  input  logic [1:0]           ipt_dec_to_sprf_mode,
  output logic [DMEMADDRW-1:0] opt_sprf_to_wrp_addr,
  output logic                 opt_sprf_to_wrp_vld,
  output logic                 opt_sprf_wrap
);

  localparam logic [1:0] FLD_CUR   = 2'b00;
  localparam logic [1:0] FLD_BASE  = 2'b01;
  localparam logic [1:0] FLD_LIMIT = 2'b10;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;

  logic [DMEMADDRW-1:0] cur_q   [NPTR];
  logic [DMEMADDRW-1:0] base_q  [NPTR];
  logic [DMEMADDRW-1:0] limit_q [NPTR];

  logic [DMEMADDRW-1:0] rd_cur;
  logic [DMEMADDRW-1:0] rd_base;
  logic [DMEMADDRW-1:0] rd_limit;
  logic [DMEMADDRW-1:0] mod_cur;
  logic                 mod_wrap;
  logic                 cur_load_hit;

  // Post-modify operates on the pre-edge pointer values, so a same-cycle
  // base/limit load never affects the wrap decision of the current access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_cur   = cur_q[ipt_dec_to_sprf_rd_sel];
    rd_base  = base_q[ipt_dec_to_sprf_rd_sel];
    rd_limit = limit_q[ipt_dec_to_sprf_rd_sel];
    mod_cur  = rd_cur;
    mod_wrap = 1'b0;
    unique case (ipt_dec_to_sprf_mode)
      MODE_INC: begin
        if (rd_cur == rd_limit) begin
          mod_cur  = rd_base;
          mod_wrap = 1'b1;
        end else begin
          mod_cur  = rd_cur + 1'b1;
        end
      end
      MODE_DEC: begin
        if (rd_cur == rd_base) begin
          mod_cur  = rd_limit;
          mod_wrap = 1'b1;
        end else begin
          mod_cur  = rd_cur - 1'b1;
        end
      end
      default: ;
    endcase
    cur_load_hit = ipt_dec_to_sprf_wr_en && (ipt_dec_to_sprf_wr_fld == FLD_CUR) &&
                   (ipt_dec_to_sprf_wr_sel == ipt_dec_to_sprf_rd_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pointer arrays are reset explicitly because their reset values are architectural.
      for (int i = 0; i < NPTR; i++) begin
        cur_q[i]   <= '0;
        base_q[i]  <= '0;
        limit_q[i] <= '1;
      end
      opt_sprf_to_wrp_addr <= '0;
      opt_sprf_to_wrp_vld  <= 1'b0;
      opt_sprf_wrap        <= 1'b0;
    end else if (t_cs) begin
      // NOTE: non-blocking assignments only, so every read above sees pre-edge state.
      opt_sprf_to_wrp_vld <= ipt_dec_to_sprf_rd_en;
      opt_sprf_wrap       <= ipt_dec_to_sprf_rd_en && mod_wrap && !cur_load_hit;
      if (ipt_dec_to_sprf_rd_en) begin
        opt_sprf_to_wrp_addr <= rd_cur;
        if (!cur_load_hit) begin
          cur_q[ipt_dec_to_sprf_rd_sel] <= mod_cur;
        end
      end
      if (ipt_dec_to_sprf_wr_en) begin
        unique case (ipt_dec_to_sprf_wr_fld)
          FLD_CUR:   cur_q[ipt_dec_to_sprf_wr_sel]   <= ipt_dec_to_sprf_wr_data;
          FLD_BASE:  base_q[ipt_dec_to_sprf_wr_sel]  <= ipt_dec_to_sprf_wr_data;
          FLD_LIMIT: limit_q[ipt_dec_to_sprf_wr_sel] <= ipt_dec_to_sprf_wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprf_addr_gen.sv
// Scoreboard bench for sprf_addr_gen: a behavioural model pushes expected outputs
// when stimulus is driven; they are popped and compared one cycle later.
module tb_sprf_addr_gen;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          t_cs;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [1:0]    wr_fld;
  logic [AW-1:0] wr_data;
  logic          rd_en;
  logic [1:0]    rd_sel;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic          vld;
  logic          wrap;

  always #5 clk = ~clk;

  sprf_addr_gen #(.DMEMADDRW(AW), .NPTR(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .t_cs                    (t_cs),
    .ipt_dec_to_sprf_wr_en   (wr_en),
    .ipt_dec_to_sprf_wr_sel  (wr_sel),
    .ipt_dec_to_sprf_wr_fld  (wr_fld),
    .ipt_dec_to_sprf_wr_data (wr_data),
    .ipt_dec_to_sprf_rd_en   (rd_en),
    .ipt_dec_to_sprf_rd_sel  (rd_sel),
    .ipt_dec_to_sprf_mode    (mode),
    .opt_sprf_to_wrp_addr    (addr),
    .opt_sprf_to_wrp_vld     (vld),
    .opt_sprf_wrap           (wrap)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          vld;
    logic          wrap;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_cur   [4];
  logic [AW-1:0] m_base  [4];
  logic [AW-1:0] m_limit [4];
  logic [AW-1:0] m_addr;
  logic          m_vld;
  logic          m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the block description, one edge at a time.
  task automatic model_edge();
    logic [AW-1:0] c, b, l, nc;
    logic          w;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cur[i] = '0; m_base[i] = '0; m_limit[i] = '1;
      end
      m_addr = '0; m_vld = 1'b0; m_wrap = 1'b0;
    end else if (t_cs) begin
      c = m_cur[rd_sel]; b = m_base[rd_sel]; l = m_limit[rd_sel];
      nc = c; w = 1'b0;
      if (mode == 2'b01) begin
        if (c == l) begin nc = b; w = 1'b1; end else nc = c + 1'b1;
      end else if (mode == 2'b10) begin
        if (c == b) begin nc = l; w = 1'b1; end else nc = c - 1'b1;
      end
      m_vld  = rd_en;
      m_wrap = 1'b0;
      if (rd_en) begin
        m_addr = c;
        if (!(wr_en && wr_fld == 2'b00 && wr_sel == rd_sel)) begin
          m_cur[rd_sel] = nc;
          m_wrap = w;
        end
      end
      if (wr_en) begin
        case (wr_fld)
          2'b00: m_cur[wr_sel]   = wr_data;
          2'b01: m_base[wr_sel]  = wr_data;
          2'b10: m_limit[wr_sel] = wr_data;
          default: ;
        endcase
      end
    end
  endtask

  // Drive one cycle at the falling edge, push the expectation, compare one cycle later.
  task automatic step(input logic rst, input logic tcs, input logic wen, input logic [1:0] wsel,
                      input logic [1:0] wfld, input logic [AW-1:0] wdata, input logic ren,
                      input logic [1:0] rsel, input logic [1:0] md);
    exp_t e;
    reset = rst; t_cs = tcs; wr_en = wen; wr_sel = wsel; wr_fld = wfld; wr_data = wdata;
    rd_en = ren; rd_sel = rsel; mode = md;
    model_edge();
    e.addr = m_addr; e.vld = m_vld; e.wrap = m_wrap;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_vld", {31'd0, vld}, {31'd0, e.vld});
      check("sb_wrap", {31'd0, wrap}, {31'd0, e.wrap});
      check("sb_addr", {22'd0, addr}, {22'd0, e.addr});
    end
  endtask

  task automatic rd(input logic [1:0] sel, input logic [1:0] md);
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1, sel, md);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] fld, input logic [AW-1:0] data);
    step(1'b0, 1'b1, 1'b1, sel, fld, data, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    reset = 1'b1; t_cs = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_fld = '0; wr_data = '0;
    rd_en = 1'b0; rd_sel = '0; mode = '0;
    @(negedge clk);
    // Reset with an access pending: access discarded.
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1, 2'd0, 2'd1);
    step(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 10'h3, 1'b1, 2'd0, 2'd1);
    check("rst_vld", {31'd0, vld}, 32'd0);

    // Sequential post-increment from reset state.
    rd(2'd0, 2'b01); check("inc_a0", {22'd0, addr}, 32'h0);
    rd(2'd0, 2'b01); check("inc_a1", {22'd0, addr}, 32'h1);
    rd(2'd0, 2'b01); check("inc_a2", {22'd0, addr}, 32'h2);
    rd(2'd0, 2'b00); check("inc_cur", {22'd0, addr}, 32'h3);

    // Wrap at limit on +1.
    wr(2'd1, 2'b01, 10'h100); wr(2'd1, 2'b10, 10'h102); wr(2'd1, 2'b00, 10'h102);
    rd(2'd1, 2'b01); check("incwrap_a", {22'd0, addr}, 32'h102); check("incwrap_w", {31'd0, wrap}, 32'd1);
    rd(2'd1, 2'b01); check("incwrap_a2", {22'd0, addr}, 32'h100); check("incwrap_w2", {31'd0, wrap}, 32'd0);

    // Wrap at base on -1.
    wr(2'd2, 2'b01, 10'h010); wr(2'd2, 2'b00, 10'h010);
    rd(2'd2, 2'b10); check("decwrap_a", {22'd0, addr}, 32'h010); check("decwrap_w", {31'd0, wrap}, 32'd1);
    rd(2'd2, 2'b00); check("decwrap_cur", {22'd0, addr}, 32'h3FF);

    // Same-pointer cur load collides with access: load wins, no wrap.
    wr(2'd3, 2'b00, 10'h020);
    step(1'b0, 1'b1, 1'b1, 2'd3, 2'b00, 10'h055, 1'b1, 2'd3, 2'b01);
    check("coll_a", {22'd0, addr}, 32'h020); check("coll_w", {31'd0, wrap}, 32'd0);
    rd(2'd3, 2'b00); check("coll_cur", {22'd0, addr}, 32'h055);

    // Same-pointer limit load: modify uses old limit (0x055), new limit also lands.
    wr(2'd3, 2'b10, 10'h055);
    step(1'b0, 1'b1, 1'b1, 2'd3, 2'b10, 10'h060, 1'b1, 2'd3, 2'b01);
    check("lim_w", {31'd0, wrap}, 32'd1);
    rd(2'd3, 2'b00); check("lim_cur", {22'd0, addr}, 32'h000);

    // Different pointers, reserved field, base==limit, out-of-range and modulo cases.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 10'h007, 1'b1, 2'd1, 2'b10);
    wr(2'd0, 2'b11, 10'h1AB);
    rd(2'd0, 2'b00); check("rsvd_cur", {22'd0, addr}, 32'h007);
    wr(2'd0, 2'b01, 10'h005); wr(2'd0, 2'b10, 10'h005); wr(2'd0, 2'b00, 10'h005);
    rd(2'd0, 2'b01); check("eq_inc_w", {31'd0, wrap}, 32'd1);
    rd(2'd0, 2'b10); check("eq_dec_a", {22'd0, addr}, 32'h005); check("eq_dec_w", {31'd0, wrap}, 32'd1);
    wr(2'd0, 2'b00, 10'h200);
    rd(2'd0, 2'b01); rd(2'd0, 2'b00); check("oor_cur", {22'd0, addr}, 32'h201);
    wr(2'd1, 2'b01, 10'h010); wr(2'd1, 2'b10, 10'h020); wr(2'd1, 2'b00, 10'h3FF);
    rd(2'd1, 2'b01); rd(2'd1, 2'b10); check("mod_inc", {22'd0, addr}, 32'h000);
    rd(2'd1, 2'b00); check("mod_dec", {22'd0, addr}, 32'h3FF);

    // Idle: vld drops, addr holds.
    idle(); check("idle_vld", {31'd0, vld}, 32'd0);

    // Freeze with rd_en held, then resume.
    rd(2'd0, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 10'h3AA, 1'b1, 2'd0, 2'b01);
    check("frz_vld", {31'd0, vld}, 32'd1);
    rd(2'd0, 2'b01); rd(2'd0, 2'b01); check("resume_a", {22'd0, addr}, 32'h203);

    // Mid-stream reset with an access pending.
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1, 2'd0, 2'b01);
    check("mrst_vld", {31'd0, vld}, 32'd0);
    rd(2'd0, 2'b10); check("mrst_cur", {22'd0, addr}, 32'h000); check("mrst_w", {31'd0, wrap}, 32'd1);
    rd(2'd0, 2'b00); check("mrst_lim", {22'd0, addr}, 32'h3FF);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 1'($urandom),
           2'($urandom), 2'($urandom), AW'($urandom_range(0, 15) + 10'h3F8 * $urandom_range(0, 1)),
           1'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
